// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the digit-network scheduler slice.
package nn_pkg;
    localparam int NUM_PIXELS  = 784;
    localparam int DATA_W      = 16;
    localparam int OUT_CLASSES = 10;
    localparam int OUT_W       = $clog2(OUT_CLASSES);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT} sched_state_t;
endpackage

// File: rtl/net_scheduler_if.sv
// Requester, network and result signals of net_scheduler bundled as one interface.
interface net_scheduler_if
    import nn_pkg::*;
#(
    parameter int dataWidth = DATA_W,
    parameter int numReq    = 2,
    parameter int outWidth  = OUT_W
);
    localparam int idW = $clog2(numReq);

    logic [numReq-1:0]           req_valid;
    logic [numReq*dataWidth-1:0] req_data;
    logic [numReq-1:0]           req_ready;
    logic                        net_valid;
    logic [dataWidth-1:0]        net_data;
    logic                        net_out_valid;
    logic [outWidth-1:0]         net_out_data;
    logic                        res_valid;
    logic [idW-1:0]              res_id;
    logic [outWidth-1:0]         res_data;
    logic                        res_err;
    logic                        busy;
    logic                        spurious_err;

    modport master (
        output req_valid, req_data, net_out_valid, net_out_data,
        input  req_ready, net_valid, net_data, res_valid, res_id, res_data,
               res_err, busy, spurious_err
    );

    modport slave (
        input  req_valid, req_data, net_out_valid, net_out_data,
        output req_ready, net_valid, net_data, res_valid, res_id, res_data,
               res_err, busy, spurious_err
    );
endinterface

// File: rtl/net_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant, wrapping.
module rr_arbiter
    import nn_pkg::*;
#(
    parameter int numReq = 2,
    parameter int idW    = $clog2(numReq)
) (
    input  logic [numReq-1:0] req,
    input  logic [idW-1:0]    last_grant,
    output logic [idW-1:0]    winner,
    output logic              any_req
);
    localparam int unsigned N = numReq;

    int unsigned idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(last_grant) + i) % N;
            if (!any_req && req[idW'(idx)]) begin
                any_req = 1'b1;
                winner  = idW'(idx);
            end
        end
    end
endmodule

// File: rtl/net_scheduler.sv
// Time-shares one digit-classifier network between requesters, one image per grant,
// with a watchdog that returns an error result if the network never answers.
module net_scheduler
    import nn_pkg::*;
#(
    parameter int dataWidth     = DATA_W,
    parameter int numPixels     = NUM_PIXELS,
    parameter int outWidth      = OUT_W,
    parameter int numReq        = 2,
    parameter int resultTimeout = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    net_scheduler_if.slave bus
);
    localparam int GW = $clog2(numReq);
    localparam int PW = $clog2(numPixels);
    localparam int WW = $clog2(resultTimeout + 1);

    localparam logic [PW-1:0] PIX_LAST   = PW'(numPixels - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(resultTimeout - 1);
    localparam logic [GW-1:0] GRANT_INIT = GW'(numReq - 1);

    sched_state_t         state, state_n;
    logic [GW-1:0]        grant, grant_n;
    logic [GW-1:0]        last_grant, last_grant_n;
    logic [GW-1:0]        winner;
    logic                 any_req;
    logic [PW-1:0]        pix_cnt, pix_cnt_n;
    logic [WW-1:0]        wait_cnt, wait_cnt_n;
    logic                 xfer;
    logic [dataWidth-1:0] sel_data;
    logic [numReq-1:0]    ready_d;

    logic                 net_valid_q, net_valid_n;
    logic [dataWidth-1:0] net_data_q, net_data_n;
    logic                 res_valid_q, res_valid_n;
    logic [GW-1:0]        res_id_q, res_id_n;
    logic [outWidth-1:0]  res_data_q, res_data_n;
    logic                 res_err_q, res_err_n;
    logic                 spurious_q, spurious_n;

    rr_arbiter #(
        .numReq (numReq),
        .idW    (GW)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign sel_data = bus.req_data[grant*dataWidth +: dataWidth];
    assign xfer     = (state == STREAM) && bus.req_valid[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= GRANT_INIT;
            pix_cnt     <= '0;
            wait_cnt    <= '0;
            net_valid_q <= 1'b0;
            net_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last_grant  <= last_grant_n;
            pix_cnt     <= pix_cnt_n;
            wait_cnt    <= wait_cnt_n;
            net_valid_q <= net_valid_n;
            net_data_q  <= net_data_n;
            res_valid_q <= res_valid_n;
            res_id_q    <= res_id_n;
            res_data_q  <= res_data_n;
            res_err_q   <= res_err_n;
            spurious_q  <= spurious_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        pix_cnt_n    = pix_cnt;
        wait_cnt_n   = wait_cnt;
        ready_d      = '0;
        net_valid_n  = 1'b0;
        net_data_n   = net_data_q;
        res_valid_n  = 1'b0;
        res_id_n     = res_id_q;
        res_data_n   = res_data_q;
        res_err_n    = res_err_q;
        // A network answer outside WAIT is flagged but otherwise ignored
        spurious_n   = spurious_q | (bus.net_out_valid && (state != WAIT));

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_n   = winner;
                    pix_cnt_n = '0;
                    state_n   = STREAM;
                end
            end
            STREAM: begin
                ready_d[grant] = 1'b1;
                if (xfer) begin
                    net_valid_n = 1'b1;
                    net_data_n  = sel_data;
                    pix_cnt_n   = pix_cnt + 1'b1;
                    if (pix_cnt == PIX_LAST) begin
                        state_n      = WAIT;
                        wait_cnt_n   = '0;
                        last_grant_n = grant;
                    end
                end
            end
            WAIT: begin
                wait_cnt_n = wait_cnt + 1'b1;
                if (bus.net_out_valid) begin
                    res_valid_n = 1'b1;
                    res_id_n    = grant;
                    res_data_n  = bus.net_out_data;
                    res_err_n   = 1'b0;
                    state_n     = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    res_valid_n = 1'b1;
                    res_id_n    = grant;
                    res_data_n  = '0;
                    res_err_n   = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready    = ready_d;
    assign bus.net_valid    = net_valid_q;
    assign bus.net_data     = net_data_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_id       = res_id_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_err      = res_err_q;
    assign bus.busy         = (state == STREAM) || (state == WAIT);
    assign bus.spurious_err = spurious_q;
endmodule
